inv_cipher_seq: RTL and testbench
=================================

# inv_cipher_seq

Iterative AES inverse cipher (FIPS-197 InvCipher): decrypts one 128-bit block per transaction, one round per clock, from a precomputed expanded key schedule. It is the decryption counterpart of the encryption datapath and takes the same key-schedule bus layout, so one key expander feeds both directions. It adds a valid/ready handshake on input and output, so it can sit between a block buffer and a consumer.

## Interface
- N, 128, key length in bits (128/192/256); informational, must match Nr/Nk
- Nr, 10, number of rounds (10/12/14)
- Nk, 4, key length in 32-bit words (4/6/8)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  ciphertext block on `in` is valid
- in_ready  out  1  block can accept a new ciphertext
- in  in  128  ciphertext, byte 0 in [127:120]
- word  in  128*(Nr+1)  expanded key schedule; round key r = word[128*(Nr+1)-1-128*r -: 128] (round key 0 in MSBs, round key Nr in [127:0])
- out  out  128  plaintext, byte 0 in [127:120]
- out_valid  out  1  `out` holds a finished plaintext
- out_ready  in  1  consumer takes `out`
- busy  out  1  high while in ROUND or FINAL

## Operation
- States: IDLE, ROUND, FINAL, DONE. Round counter `rc`, width clog2(Nr+1).
- IDLE: in_ready=1. On in_valid&&in_ready: state_reg <= in ^ rk[Nr]; rc <= Nr-1; go ROUND.
- ROUND: state_reg <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state_reg)), rk[rc])); rc <= rc-1; go FINAL when rc==1, else stay.
- FINAL: out <= AddRoundKey(InvSubBytes(InvShiftRows(state_reg)), rk[0]); out_valid <= 1; go DONE.
- DONE: hold out and out_valid=1 until out_ready=1; on that edge out_valid <= 0, go IDLE. `out` keeps last value after handshake.
- in_ready is 1 only in IDLE; a new block is never accepted in the cycle the previous result is consumed.
- `word` is not captured: it must be stable from the accept edge through the FINAL edge. Changing it mid-block gives undefined plaintext (no error flag).
- InvSubBytes uses the inverse S-box (combinational LUT, 16 instances); InvShiftRows rotates row r right by r; InvMixColumns uses matrix {0e,0b,0d,09} in GF(2^8) mod x^8+x^4+x^3+x+1.
- No X-checks on inputs; behaviour is defined by state only.

## Timing
- Reset (async assert, any state): state IDLE, rc=0, state_reg=0, out=0, out_valid=0, in_ready=1, busy=0. Reset mid-block aborts it; no partial output.
- Latency: with accept at edge 0, out_valid rises after edge Nr (rounds at edges 1..Nr-1, FINAL at edge Nr). That is 10 cycles for AES-128 and 14 for AES-256.
- Throughput: one block per Nr+2 cycles when out_ready is held high (DONE cycle plus IDLE accept cycle).
- in_valid while not in_ready is ignored; the source must hold `in` until accepted.
- out_ready while out_valid=0 has no effect.
- in_ready, busy and out_valid are registered-state decodes; no combinational path from in_valid/out_ready to in_ready/out_valid.

## Test plan
- AES-128 (FIPS-197 App. B): key 2b7e151628aed2a6abf7158809cf4f3c, in 3925841d02dc09fbdc118597196a0b32 -> out 3243f6a8885a308d313198a2e0370734; out_valid exactly 10 edges after accept.
- AES-128 (App. C.1, key 000102…0f): in 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff. AES-256 (Nr=14, Nk=8, key 000102…1f): in 8ea2b7ca516745bfeafc49904b496089 -> same plaintext, latency 14.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid. Required: out stable, in_ready=0, and an in_valid pulse during DONE is not accepted. Raise out_ready: one cycle later in_ready=1.
- Back-to-back: in_valid and out_ready held high with two blocks queued. Required: both plaintexts correct, accepts spaced Nr+2 cycles apart.
- Reset mid-operation: assert rst at rc=5 asynchronously between edges. Required: out=0, out_valid=0, in_ready=1, busy=0 immediately. After release, a fresh App. B block decrypts correctly.
- Round-trip: 100 random key/plaintext pairs through the existing encryption block, then this block. Required: out equals the original plaintext every time.

Source files
------------

// File: rtl/inv_cipher_seq.sv
// inv_cipher_seq: iterative AES inverse cipher (InvCipher), one round per clock.
// The ciphertext is whitened with the last round key on accept. Each following
// cycle runs one inverse round until the final round produces the plaintext,
// which is held until the consumer takes it.
module inv_cipher_seq #(
    parameter int N  = 128,
    parameter int Nr = 10,
    parameter int Nk = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          in,
    input  logic [128*(Nr+1)-1:0] word,
    output logic [127:0]          out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int RCW = $clog2(Nr + 1);

    // Key length, round count and word count must describe the same AES variant.
    if (N != 32 * Nk || Nr != Nk + 6) begin : g_bad_cfg
        $error("inv_cipher_seq: inconsistent N/Nr/Nk");
    end

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_e;

    // Inverse S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a constant 4-bit coefficient in GF(2^8).
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return (k[0] ? b : 8'h00) ^ (k[1] ? b2 : 8'h00) ^
               (k[2] ? b4 : 8'h00) ^ (k[3] ? b8 : 8'h00);
    endfunction

    // InvShiftRows (row r rotated right by r) followed by InvSubBytes.
    function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
        logic [127:0] t;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127-8*(4*c+r) -: 8] =
                    INV_SBOX[2047-8*s[127-8*(4*((c-r+4)%4)+r) -: 8] -: 8];
            end
        end
        return t;
    endfunction

    // InvMixColumns with the circulant matrix {0e,0b,0d,09}.
    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] t;
        logic [7:0]   a [4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
            for (int r = 0; r < 4; r++) begin
                t[127-8*(4*c+r) -: 8] = gmul(a[r], 4'he) ^ gmul(a[(r+1)%4], 4'hb) ^
                                        gmul(a[(r+2)%4], 4'hd) ^ gmul(a[(r+3)%4], 4'h9);
            end
        end
        return t;
    endfunction

    logic [127:0] rk [0:Nr];
    for (genvar r = 0; r <= Nr; r++) begin : g_rk
        assign rk[r] = word[128*(Nr+1)-1-128*r -: 128];
    end

    state_e       state_q, state_d;
    logic [RCW-1:0] rc_q, rc_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] out_q, out_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] sub_shift;

    assign sub_shift = inv_sub_shift(blk_q);

    // Next-state logic: one inverse round per cycle, handshakes at both ends.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d     = state_q;
        rc_d        = rc_q;
        blk_d       = blk_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    blk_d   = in ^ rk[Nr];
                    rc_d    = RCW'(Nr - 1);
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                blk_d = inv_mix(sub_shift ^ rk[rc_q]);
                rc_d  = rc_q - RCW'(1);
                if (rc_q == RCW'(1)) state_d = S_FINAL;
            end
            S_FINAL: begin
                out_d       = sub_shift ^ rk[0];
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            rc_q        <= '0;
            blk_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rc_q        <= rc_d;
            blk_q       <= blk_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_ROUND) || (state_q == S_FINAL);
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_inv_cipher_seq.sv
// tb_inv_cipher_seq: directed and round-trip checks for inv_cipher_seq with
// AES-128 and AES-256 instances. Key schedules and ciphertexts for random
// blocks come from a forward-cipher model written here.
module tb_inv_cipher_seq;

    typedef struct {
        logic [255:0] key;
        int           nk;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic              in_valid_a = 1'b0, out_ready_a = 1'b0;
    logic              in_ready_a, out_valid_a, busy_a;
    logic [127:0]      in_a = '0, out_a;
    logic [128*11-1:0] word_a = '0;

    logic              in_valid_b = 1'b0, out_ready_b = 1'b0;
    logic              in_ready_b, out_valid_b, busy_b;
    logic [127:0]      in_b = '0, out_b;
    logic [128*15-1:0] word_b = '0;

    int n_checks = 0;
    int n_err    = 0;
    logic [7:0] sbox_t [256];

    always #5 clk = ~clk;

    inv_cipher_seq #(.N(128), .Nr(10), .Nk(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in(in_a),
        .word(word_a), .out(out_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .busy(busy_a));

    inv_cipher_seq #(.N(256), .Nr(14), .Nk(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in(in_b),
        .word(word_b), .out(out_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .busy(busy_b));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // ---------------- forward AES model ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[x] = b;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Key schedule, LSB-aligned: round key r at [128*(nr+1)-1-128*r -: 128].
    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1919:0] ks;
        int            nr;
        nr   = nk + 6;
        rcon = 8'h01;
        ks   = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++)
            ks[128*(nr+1)-1-128*r -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    function automatic logic [127:0] rkey(input logic [1919:0] ks, input int nr, input int r);
        return ks[128*(nr+1)-1-128*r -: 128];
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] t;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[127-8*(4*c+r) -: 8] = sbox_t[s[127-8*(4*((c+r)%4)+r) -: 8]];
        return t;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] t;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            t[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return t;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1919:0] ks,
                                             input int nr);
        logic [127:0] s;
        s = pt ^ rkey(ks, nr, 0);
        for (int r = 1; r < nr; r++) s = mix(sub_shift(s)) ^ rkey(ks, nr, r);
        return sub_shift(s) ^ rkey(ks, nr, nr);
    endfunction

    // ---------------- transaction helper ----------------
    // One block through instance sel (0: AES-128, 1: AES-256); lat counts edges
    // from accept to out_valid.
    task automatic run_block(input bit sel, input logic [127:0] ct,
                             output logic [127:0] pt, output int lat);
        @(negedge clk);
        check1("in_ready before accept", sel ? in_ready_b : in_ready_a, 1'b1);
        if (sel) begin in_b = ct; in_valid_b = 1'b1; end
        else     begin in_a = ct; in_valid_a = 1'b1; end
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        check1("busy after accept", sel ? busy_b : busy_a, 1'b1);
        lat = 0;
        while (!(sel ? out_valid_b : out_valid_a) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        pt = sel ? out_b : out_a;
        @(negedge clk);
        if (sel) out_ready_b = 1'b1; else out_ready_a = 1'b1;
        @(posedge clk); #1;
        out_ready_a = 1'b0;
        out_ready_b = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t          vecs [11];
        logic [1919:0] ks;
        logic [127:0]  got, hold;
        logic [127:0]  bb_ct [2], bb_pt [2], bb_got [2];
        logic          acc, done, stable, quiet;
        int            lat, cyc, na, no;
        int            acc_cyc [2];

        build_sbox();

        vecs[0] = '{key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, nk: 4,
                    ct: 128'h3925841d02dc09fbdc118597196a0b32,
                    pt: 128'h3243f6a8885a308d313198a2e0370734};
        vecs[1] = '{key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, nk: 4,
                    ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    pt: 128'h00112233445566778899aabbccddeeff};
        vecs[2] = '{key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    nk: 8, ct: 128'h8ea2b7ca516745bfeafc49904b496089,
                    pt: 128'h00112233445566778899aabbccddeeff};
        for (int i = 3; i < 11; i++) begin
            vecs[i].nk  = (i % 2 == 1) ? 4 : 8;
            vecs[i].key = {$urandom(), $urandom(), $urandom(), $urandom(),
                           $urandom(), $urandom(), $urandom(), $urandom()};
            vecs[i].pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            vecs[i].ct  = encrypt(vecs[i].pt, expand(vecs[i].key, vecs[i].nk), vecs[i].nk + 6);
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset out", out_a, 128'h0);
        check1("reset out_valid", out_valid_a, 1'b0);
        check1("reset in_ready", in_ready_a, 1'b1);
        check1("reset busy", busy_a, 1'b0);
        check1("reset in_ready 256", in_ready_b, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven known-answer and round-trip vectors.
        for (int i = 0; i < 11; i++) begin
            ks = expand(vecs[i].key, vecs[i].nk);
            if (vecs[i].nk == 8) begin
                word_b = ks;
                run_block(1'b1, vecs[i].ct, got, lat);
            end else begin
                word_a = ks[1407:0];
                run_block(1'b0, vecs[i].ct, got, lat);
            end
            check($sformatf("vec%0d plaintext", i), got, vecs[i].pt);
            check_int($sformatf("vec%0d latency", i), lat, vecs[i].nk + 6);
        end

        // Backpressure: result held for 20 cycles, in_valid pulse in DONE ignored.
        ks     = expand(vecs[0].key, 4);
        word_a = ks[1407:0];
        @(negedge clk);
        in_a       = vecs[0].ct;
        in_valid_a = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        lat = 0;
        while (!out_valid_a && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        hold = out_a;
        check("bp plaintext", hold, vecs[0].pt);
        stable = 1'b1;
        quiet  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 5) begin in_a = vecs[1].ct; in_valid_a = 1'b1; end
            else        in_valid_a = 1'b0;
            @(posedge clk); #1;
            if (out_a !== hold || out_valid_a !== 1'b1) stable = 1'b0;
            if (in_ready_a !== 1'b0 || busy_a !== 1'b0) quiet = 1'b0;
        end
        in_valid_a = 1'b0;
        check1("bp out held", stable, 1'b1);
        check1("bp in_ready low and idle", quiet, 1'b1);
        @(negedge clk);
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        out_ready_a = 1'b0;
        check1("bp in_ready after consume", in_ready_a, 1'b1);
        check1("bp out_valid after consume", out_valid_a, 1'b0);
        check("bp out kept after consume", out_a, hold);
        repeat (3) @(posedge clk);
        #1;
        check1("bp no ghost block", busy_a | out_valid_a, 1'b0);

        // Back-to-back: in_valid and out_ready held high, two blocks queued.
        bb_ct[0]  = vecs[0].ct;
        bb_pt[0]  = vecs[0].pt;
        bb_pt[1]  = {$urandom(), $urandom(), $urandom(), $urandom()};
        bb_ct[1]  = encrypt(bb_pt[1], ks, 10);
        bb_got[0] = '0;
        bb_got[1] = '0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        na  = 0;
        no  = 0;
        cyc = 0;
        in_a        = bb_ct[0];
        in_valid_a  = 1'b1;
        out_ready_a = 1'b1;
        while (no < 2 && cyc < 100) begin
            acc  = in_valid_a && in_ready_a;
            done = out_valid_a && out_ready_a;
            got  = out_a;
            @(posedge clk);
            cyc++;
            if (acc && na < 2) begin acc_cyc[na] = cyc; na++; end
            if (done) begin bb_got[no] = got; no++; end
            #1;
            if (na < 2) in_a = bb_ct[na];
            else        in_valid_a = 1'b0;
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b0;
        check("b2b block0 plaintext", bb_got[0], bb_pt[0]);
        check("b2b block1 plaintext", bb_got[1], bb_pt[1]);
        check_int("b2b accept spacing", acc_cyc[1] - acc_cyc[0], 12);

        // Reset mid-block at rc=5 (four round edges after accept).
        @(negedge clk);
        in_a       = vecs[0].ct;
        in_valid_a = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midreset out", out_a, 128'h0);
        check1("midreset out_valid", out_valid_a, 1'b0);
        check1("midreset in_ready", in_ready_a, 1'b1);
        check1("midreset busy", busy_a, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_block(1'b0, vecs[0].ct, got, lat);
        check("post-reset plaintext", got, vecs[0].pt);
        check_int("post-reset latency", lat, 10);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
